// File: rtl/memory_pkg.sv
// Shared memory sizing constants and the wait-state FSM encoding
// used by the data memory blocks.
package memory_pkg;

    localparam int DATA_MEM_SIZE_WORDS = 1024;
    localparam int DATA_MEM_SIZE_BYTES = DATA_MEM_SIZE_WORDS * 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_mem_wait.sv
// Byte-maskable data memory with a configurable number of wait cycles per access.
// Requests are captured on acceptance and performed once the wait counter expires.
module data_mem_wait
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WORDS = memory_pkg::DATA_MEM_SIZE_WORDS,
    parameter int LATENCY    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mem_req_i,
    input  logic                    write_enable_i,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_i,
    input  logic [31:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    output logic [DATA_WIDTH-1:0]   read_data_o,
    output logic                    ready_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BE_W);
    localparam int IDX_W = $clog2(SIZE_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    logic [DATA_WIDTH-1:0] ram [SIZE_WORDS-1:0];

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_we;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_capture;
    logic                  w_access;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_acc_idx;
    logic                  w_acc_we;
    logic [BE_W-1:0]       w_acc_be;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic                  w_unused_addr;

    // Upper address bits wrap the index; byte-offset bits are ignored.
    assign w_idx         = addr_i[OFFS +: IDX_W];
    assign w_unused_addr = ^{addr_i[31:OFFS+IDX_W], addr_i[OFFS-1:0]};

    // Next-state logic: zero latency performs the access at the accepting edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req_i) begin
                    if (LATENCY == 0) begin
                        w_access = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = LAT_LOAD;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Access operands: captured values while waiting, live inputs otherwise.
    always_comb begin
        w_acc_idx   = w_idx;
        w_acc_we    = write_enable_i;
        w_acc_be    = byte_enable_i;
        w_acc_wdata = write_data_i;
        if (r_state == BUSY) begin
            w_acc_idx   = r_idx;
            w_acc_we    = r_we;
            w_acc_be    = r_be;
            w_acc_wdata = r_wdata;
        end else begin
            w_acc_idx   = w_idx;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture so input changes during BUSY have no effect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_idx   <= w_idx;
            r_we    <= write_enable_i;
            r_be    <= byte_enable_i;
            r_wdata <= write_data_i;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_access && w_acc_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (w_acc_be[k]) begin
                    ram[w_acc_idx][8*k +: 8] <= w_acc_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read data register holds until the next read access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_access && !w_acc_we) begin
            r_rdata <= ram[w_acc_idx];
        end
    end

    assign read_data_o = r_rdata;
    assign ready_o     = (r_state == IDLE);

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed bench for data_mem_wait: zero-latency table, multi-cycle waits,
// reset during a pending access and a 64-bit back-to-back sequence.
module tb_data_mem_wait;
    import memory_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req [3];
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd [3];
    logic        rdy [3];

    logic        req64;
    logic        we64;
    logic [7:0]  be64;
    logic [31:0] addr64;
    logic [63:0] wd64;
    logic [63:0] rd64;
    logic        rdy64;

    int n_vec;
    int n_err;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [14];

    data_mem_wait #(.DATA_WIDTH(32), .LATENCY(0)) u_l0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[0]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wdata),
        .read_data_o(rd[0]), .ready_o(rdy[0])
    );
    data_mem_wait #(.DATA_WIDTH(32), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[1]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wdata),
        .read_data_o(rd[1]), .ready_o(rdy[1])
    );
    data_mem_wait #(.DATA_WIDTH(32), .LATENCY(4)) u_l4 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[2]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wdata),
        .read_data_o(rd[2]), .ready_o(rdy[2])
    );
    data_mem_wait #(.DATA_WIDTH(64), .LATENCY(1)) u_w64 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req64), .write_enable_i(we64),
        .byte_enable_i(be64), .addr_i(addr64), .write_data_i(wd64),
        .read_data_o(rd64), .ready_o(rdy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge once the instance is idle again.
    task automatic run_acc(input int inst, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d);
        int n;
        we = w; be = b; addr = a; wdata = d;
        req[inst] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[inst] = 1'b0;
        n = 0;
        while (!rdy[inst] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("ready_timeout", 64'(rdy[inst]), 64'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        req64 = 1'b0; we64 = 1'b0; be64 = 8'h0; addr64 = 32'h0; wd64 = 64'h0;

        tbl[0]  = '{1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h00000000, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b1, 4'h5, 32'h10, 32'hAABBCCDD, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h00000000, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 1'b1, 4'hF, 32'h14, 32'hCAFEF00D, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 1'b1, 4'h0, 32'h14, 32'h12345678, 32'h11BB33DD};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 32'h14, 32'h00000000, 32'hCAFEF00D};
        tbl[8]  = '{1'b1, 1'b1, 4'hF, 32'(DATA_MEM_SIZE_WORDS * 4 + 8), 32'h5A5A5A5A, 32'hCAFEF00D};
        tbl[9]  = '{1'b1, 1'b0, 4'hF, 32'h08, 32'h00000000, 32'h5A5A5A5A};
        tbl[10] = '{1'b0, 1'b0, 4'hF, 32'h14, 32'h00000000, 32'h5A5A5A5A};
        tbl[11] = '{1'b1, 1'b0, 4'hF, 32'h13, 32'h00000000, 32'h11BB33DD};
        tbl[12] = '{1'b1, 1'b1, 4'hA, 32'h14, 32'h00FF00FF, 32'h11BB33DD};
        tbl[13] = '{1'b1, 1'b0, 4'hF, 32'h14, 32'h00000000, 32'h00FE000D};

        repeat (3) @(negedge clk);
        check("rst_ready_l0", 64'(rdy[0]), 64'd1);
        check("rst_ready_l3", 64'(rdy[1]), 64'd1);
        check("rst_rdata_l3", 64'(rd[1]), 64'd0);
        check("rst_rdata_w64", rd64, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-latency table: each access lands at the edge it is presented.
        for (int i = 0; i < 14; i++) begin
            we = tbl[i].we; be = tbl[i].be; addr = tbl[i].addr; wdata = tbl[i].wdata;
            req[0] = tbl[i].req;
            check($sformatf("l0_ready_pre[%0d]", i), 64'(rdy[0]), 64'd1);
            @(posedge clk);
            @(negedge clk);
            req[0] = 1'b0;
            check($sformatf("l0_rdata[%0d]", i), 64'(rd[0]), 64'(tbl[i].exp_rd));
            check($sformatf("l0_ready[%0d]", i), 64'(rdy[0]), 64'd1);
        end

        // Latency 3 read: busy for exactly three cycles, late address change ignored.
        run_acc(1, 1'b1, 4'hF, 32'h20, 32'h13579BDF);
        we = 1'b0; be = 4'hF; addr = 32'h20; wdata = 32'h0;
        req[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("l3_busy_ready[%0d]", c), 64'(rdy[1]), 64'd0);
            check($sformatf("l3_busy_rdata[%0d]", c), 64'(rd[1]), 64'd0);
            @(negedge clk);
            req[1] = 1'b0;
        end
        check("l3_done_ready", 64'(rdy[1]), 64'd1);
        check("l3_done_rdata", 64'(rd[1]), 64'h13579BDF);
        run_acc(1, 1'b0, 4'hF, 32'h24, 32'h0);
        check("l3_no_stray_write", 64'(rd[1] === 32'hFFFFFFFF), 64'd0);

        // 64-bit, latency 1: back-to-back writes, ready pattern 1,0,1,0.
        we64 = 1'b1; be64 = 8'hFF; addr64 = 32'h0; wd64 = 64'h0123456789ABCDEF;
        req64 = 1'b1;
        check("w64_rdy0", 64'(rdy64), 64'd1);
        @(posedge clk); @(negedge clk);
        addr64 = 32'h8; wd64 = 64'hFEDCBA9876543210;
        check("w64_rdy1", 64'(rdy64), 64'd0);
        @(posedge clk); @(negedge clk);
        check("w64_rdy2", 64'(rdy64), 64'd1);
        @(posedge clk); @(negedge clk);
        req64 = 1'b0;
        check("w64_rdy3", 64'(rdy64), 64'd0);
        @(posedge clk); @(negedge clk);
        we64 = 1'b0; addr64 = 32'h0; req64 = 1'b1;
        @(posedge clk); @(negedge clk);
        req64 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("w64_rd0", rd64, 64'h0123456789ABCDEF);
        addr64 = 32'h8; req64 = 1'b1;
        @(posedge clk); @(negedge clk);
        req64 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("w64_rd1", rd64, 64'hFEDCBA9876543210);

        // Latency 4: reset two cycles into a pending write drops it.
        run_acc(2, 1'b1, 4'hF, 32'h4, 32'h00000000);
        run_acc(2, 1'b1, 4'hF, 32'h8, 32'h600DF00D);
        run_acc(2, 1'b0, 4'hF, 32'h8, 32'h0);
        check("l4_pre_rdata", 64'(rd[2]), 64'h600DF00D);
        we = 1'b1; be = 4'hF; addr = 32'h4; wdata = 32'hFFFFFFFF;
        req[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        check("l4_busy", 64'(rdy[2]), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("l4_rst_ready", 64'(rdy[2]), 64'd1);
        check("l4_rst_rdata", 64'(rd[2]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_acc(2, 1'b0, 4'hF, 32'h4, 32'h0);
        check("l4_dropped_write", 64'(rd[2]), 64'd0);
        run_acc(2, 1'b0, 4'hF, 32'h8, 32'h0);
        check("l4_mem_kept", 64'(rd[2]), 64'h600DF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter SIZE_WORDS, default memory_pkg::DATA_MEM_SIZE_WORDS: depth in words; must be a power of two.
REQ-003 SHALL have parameter LATENCY, default 0: number of wait cycles per access; legal range 0..15.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mem_req_i, input, 1 bit: access request.
REQ-007 SHALL have port write_enable_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port byte_enable_i, input, DATA_WIDTH/8 bits: per-byte write mask.
REQ-009 SHALL have port addr_i, input, 32 bits: byte address.
REQ-010 SHALL have port write_data_i, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port read_data_o, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have port ready_o, output, 1 bit: high when idle, meaning it can accept a request and the previous access is complete.

Function
REQ-013 SHALL compute OFFS = $clog2(DATA_WIDTH/8) and word index = addr_i[OFFS +: $clog2(SIZE_WORDS)]; upper address bits are ignored, so the index wraps modulo SIZE_WORDS.
REQ-014 SHALL implement an FSM with states IDLE and BUSY; ready_o = (state == IDLE) combinationally.
REQ-015 SHALL accept a request on a rising edge where state is IDLE and mem_req_i is 1; it is ignored in every other case.
REQ-016 SHALL, with LATENCY = 0, perform an accepted access at the accepting edge and remain in IDLE, so ready_o is constant 1 after reset.
REQ-017 SHALL, with LATENCY = N > 0, on acceptance:
- capture index, write_enable_i, byte_enable_i and write_data_i;
- enter BUSY and load the wait counter with N-1.
REQ-018 SHALL, in BUSY, decrement the counter every cycle; at the edge where the counter equals 0 it performs the captured access and returns to IDLE. ready_o is therefore low for exactly N cycles.
REQ-019 SHALL ignore input changes during BUSY; only the captured values are used.
REQ-020 SHALL, on a read access, set read_data_o <= ram[index] at the access edge and hold it until the next read access.
REQ-021 SHALL, on a write access, update byte k only where byte_enable_i[k] = 1; other bytes and read_data_o are unchanged.
REQ-022 SHALL leave memory unchanged on a write with byte_enable_i = 0.
REQ-023 SHALL allow a new request in the same cycle ready_o rises (back-to-back); that request is accepted at the following edge.

Reset
REQ-024 SHALL, while rst_ni = 0, asynchronously force state = IDLE, counter = 0 and read_data_o = 0; ready_o is 1.
REQ-025 SHALL drop any pending BUSY access on reset: no write is performed and read_data_o stays 0.
REQ-026 SHALL NOT reset memory contents.

Structure
REQ-027 SHALL take DATA_MEM_SIZE_WORDS/BYTES from memory_pkg; memory_pkg also gains the FSM state enum mem_state_t (IDLE, BUSY).
REQ-028 SHALL be a single module without sub-modules; the storage array is named ram and indexed [SIZE_WORDS-1:0] of [DATA_WIDTH-1:0].

Verification
REQ-029 SHALL cover LATENCY=0 write then read: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> read_data_o = 0xDEADBEEF one edge later; ready_o always 1.
REQ-030 SHALL cover partial write at LATENCY=0: ram[4] = 0x11223344; write 0xAABBCCDD to 0x10 with be=4'b0101, then read -> 0x11BB33DD.
REQ-031 SHALL cover LATENCY=3 read of 0x20: ready_o low for exactly 3 cycles after acceptance; read_data_o changes only at the 3rd BUSY edge; an addr_i change during BUSY has no effect.
REQ-032 SHALL cover wrap-around: write 0x5A5A5A5A to byte address SIZE_WORDS*4 + 8 (DATA_WIDTH=32) -> ram[2] = 0x5A5A5A5A.
REQ-033 SHALL cover reset mid-BUSY: LATENCY=4 write of 0xFFFFFFFF to ram[1], which holds 0; assert rst_ni after 2 BUSY cycles -> ram[1] stays 0, ready_o = 1 and read_data_o = 0 immediately.
REQ-034 SHALL cover DATA_WIDTH=64, LATENCY=1: back-to-back writes to 0x0 and 0x8 on consecutive ready cycles, then reads -> both words correct; ready_o pattern is 1,0,1,0.
